// File: rtl/sysbus_pkg.sv
// Shared types and geometry for the system-bus memory responder.
// A memory line is four 32-bit words; the bus moves one word per request.
package sysbus_pkg;

   localparam int LINE_BYTES     = 16;
   localparam int WORDS_PER_LINE = 4;
   localparam int WORD_BYTES     = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      RESP
   } state_e;

endpackage

// File: rtl/line_merge.sv
// Replaces the masked bytes of one word inside a memory line.
// Purely combinational; unmasked bytes pass through unchanged.
module line_merge
   import sysbus_pkg::*;
#(
   parameter int LINE_W = 128
) (
   input  logic [LINE_W-1:0] line_i,
   input  logic [1:0]        word_idx_i,
   input  logic [3:0]        mask_i,
   input  logic [31:0]       word_i,
   output logic [LINE_W-1:0] line_o
);

   always_comb begin
      line_o = line_i;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (word_idx_i == 2'(w) && mask_i[b]) begin
               line_o[(w*WORD_BYTES+b)*8 +: 8] = word_i[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Bridges 32-bit system-bus requests onto a line-wide memory using
// read-modify-write for partial stores.
module sysbus_mem_responder
   import sysbus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              system_bus_en,
   input  logic              system_bus_rdwr,
   input  logic [3:0]        system_bus_mask,
   input  logic [ADDR_W-1:0] system_bus_addr,
   input  logic [31:0]       system_bus_wr_data,
   output logic [31:0]       system_bus_rd_data,
   output logic              system_bus_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-5:0] mem_addr,
   output logic [LINE_W-1:0] mem_wr_data,
   input  logic [LINE_W-1:0] mem_rd_data
);

   state_e              state_q;
   logic                rdwr_q;
   logic [3:0]          mask_q;
   logic [1:0]          widx_q;
   logic [31:0]         wdata_q;
   logic [LINE_W-1:0]   line_q;
   logic [31:0]         rd_data_q;
   logic                ready_q;
   logic                mem_en_q;
   logic                mem_we_q;
   logic [ADDR_W-5:0]   mem_addr_q;
   logic [LINE_W-1:0]   merged;
   logic                unused_addr_lsb;

   // Byte offset within the word is irrelevant: access is word-granular.
   assign unused_addr_lsb = ^system_bus_addr[1:0];

   line_merge #(
      .LINE_W (LINE_W)
   ) u_merge (
      .line_i     (line_q),
      .word_idx_i (widx_q),
      .mask_i     (mask_q),
      .word_i     (wdata_q),
      .line_o     (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rdwr_q     <= 1'b0;
         mask_q     <= '0;
         widx_q     <= '0;
         wdata_q    <= '0;
         line_q     <= '0;
         rd_data_q  <= '0;
         ready_q    <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         ready_q  <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (system_bus_en) begin
                  rdwr_q     <= system_bus_rdwr;
                  mask_q     <= system_bus_mask;
                  widx_q     <= system_bus_addr[3:2];
                  wdata_q    <= system_bus_wr_data;
                  mem_addr_q <= system_bus_addr[ADDR_W-1:4];
                  // A store with no byte enables has nothing to merge.
                  if (system_bus_rdwr && system_bus_mask == 4'b0000) begin
                     state_q <= RESP;
                     ready_q <= 1'b1;
                  end else begin
                     state_q  <= RD;
                     mem_en_q <= 1'b1;
                  end
               end
            end
            RD: begin
               state_q <= WAIT;
            end
            WAIT: begin
               line_q <= mem_rd_data;
               if (rdwr_q) begin
                  state_q  <= WR;
                  mem_en_q <= 1'b1;
                  mem_we_q <= 1'b1;
               end else begin
                  state_q   <= RESP;
                  ready_q   <= 1'b1;
                  rd_data_q <= mem_rd_data[{widx_q, 5'd0} +: 32];
               end
            end
            WR: begin
               state_q <= RESP;
               ready_q <= 1'b1;
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign system_bus_rd_data = rd_data_q;
   assign system_bus_ready   = ready_q;
   assign mem_en             = mem_en_q;
   assign mem_we             = mem_we_q;
   assign mem_addr           = mem_addr_q;
   assign mem_wr_data        = mem_we_q ? merged : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: line memory model, directed table,
// abort-on-reset sequence and random traffic against a byte-array model.
module tb_sysbus_mem_responder;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 128;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic              rdwr;
   logic [3:0]        mask;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wr_data;
   logic [31:0]       rd_data;
   logic              ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-5:0] mem_addr;
   logic [LINE_W-1:0] mem_wr_data;
   logic [LINE_W-1:0] mem_rd_data;

   sysbus_mem_responder #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .system_bus_en      (en),
      .system_bus_rdwr    (rdwr),
      .system_bus_mask    (mask),
      .system_bus_addr    (addr),
      .system_bus_wr_data (wr_data),
      .system_bus_rd_data (rd_data),
      .system_bus_ready   (ready),
      .mem_en             (mem_en),
      .mem_we             (mem_we),
      .mem_addr           (mem_addr),
      .mem_wr_data        (mem_wr_data),
      .mem_rd_data        (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [LINE_W-1:0] mem [0:255];
   logic              ld_req;
   logic [7:0]        ld_addr;
   logic [LINE_W-1:0] ld_data;
   logic              unused_hi;
   int                we_cnt;
   int                rdy_cnt;

   assign unused_hi = ^mem_addr[ADDR_W-5:8];

   always @(posedge clk) begin
      if (ld_req) begin
         mem[ld_addr] <= ld_data;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wr_data;
         else        mem_rd_data <= mem[mem_addr[7:0]];
      end
   end

   initial begin
      we_cnt  = 0;
      rdy_cnt = 0;
   end

   always @(posedge clk) begin
      if (mem_en && mem_we) we_cnt <= we_cnt + 1;
      if (ready)            rdy_cnt <= rdy_cnt + 1;
   end

   int n_chk;
   int n_fail;
   logic [7:0] ref_mem [0:511];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_write(input logic [31:0] a, input logic [3:0] m,
                              input logic [31:0] d);
      int base;
      base = int'(a) & ~3;
      for (int i = 0; i < 4; i++)
         if (m[i]) ref_mem[base+i] = d[i*8 +: 8];
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int base;
      logic [31:0] w;
      base = int'(a) & ~3;
      for (int i = 0; i < 4; i++) w[i*8 +: 8] = ref_mem[base+i];
      return w;
   endfunction

   task automatic txn(input logic rw, input logic [3:0] m,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd,
                      output int first_en, output int first_we,
                      output int n_en);
      lat      = -1;
      rd       = '0;
      first_en = -1;
      first_we = -1;
      n_en     = 0;
      @(negedge clk);
      en      = 1'b1;
      rdwr    = rw;
      mask    = m;
      addr    = a;
      wr_data = d;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_en) begin
            n_en++;
            if (first_en < 0) first_en = k;
         end
         if (mem_we && first_we < 0) first_we = k;
         if (ready) begin
            lat = k;
            rd  = rd_data;
            break;
         end
      end
      en = 1'b0;
      @(negedge clk);
      chk("ready_one_cycle", {127'd0, ready}, 128'd0);
   endtask

   typedef struct {
      logic        rw;
      logic [3:0]  m;
      logic [31:0] a;
      logic [31:0] d;
      int          lat;
      logic [31:0] rd;
      int          en_at;
      int          we_at;
      int          n_en;
   } vec_t;

   vec_t              tbl [9];
   logic [LINE_W-1:0] preload;
   logic [LINE_W-1:0] line_exp;
   int                lat, fe, fw, ne;
   logic [31:0]       rd;
   int                we0, r0;
   logic [31:0]       ra, rb, rdat;
   logic [3:0]        rm;

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst_n   = 1'b1;
      en      = 1'b0;
      rdwr    = 1'b0;
      mask    = '0;
      addr    = '0;
      wr_data = '0;
      ld_req  = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      preload = 128'h33333333_22222222_11111111_00000000;

      tbl[0] = '{1'b0, 4'h0, 32'h108, 32'h0,        3, 32'h22222222,  1, -1, 1};
      tbl[1] = '{1'b1, 4'hF, 32'h104, 32'hDEADBEEF, 4, 32'h22222222,  1,  3, 2};
      tbl[2] = '{1'b0, 4'h0, 32'h104, 32'h0,        3, 32'hDEADBEEF,  1, -1, 1};
      tbl[3] = '{1'b0, 4'h0, 32'h100, 32'h0,        3, 32'h00000000,  1, -1, 1};
      tbl[4] = '{1'b1, 4'h5, 32'h100, 32'hAABBCCDD, 4, 32'h00000000,  1,  3, 2};
      tbl[5] = '{1'b0, 4'h0, 32'h100, 32'h0,        3, 32'h00BB00DD,  1, -1, 1};
      tbl[6] = '{1'b1, 4'h0, 32'h10C, 32'hFFFFFFFF, 1, 32'h00BB00DD, -1, -1, 0};
      tbl[7] = '{1'b0, 4'h0, 32'h10C, 32'h0,        3, 32'h33333333,  1, -1, 1};
      tbl[8] = '{1'b0, 4'h0, 32'h10A, 32'h0,        3, 32'h22222222,  1, -1, 1};

      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
      for (int i = 0; i < 16; i++) ref_mem[256+i] = preload[i*8 +: 8];

      #1 rst_n = 1'b0;
      #1;
      chk("rst_ready",    {127'd0, ready},  128'd0);
      chk("rst_mem_en",   {127'd0, mem_en}, 128'd0);
      chk("rst_mem_we",   {127'd0, mem_we}, 128'd0);
      chk("rst_rd_data",  {96'd0, rd_data}, 128'd0);
      chk("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
      chk("rst_wr_data",  mem_wr_data,      128'd0);

      for (int l = 0; l < 32; l++) begin
         @(negedge clk);
         ld_req  = 1'b1;
         ld_addr = 8'(l);
         ld_data = (l == 16) ? preload : '0;
      end
      @(negedge clk);
      ld_req = 1'b0;
      rst_n  = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         txn(tbl[i].rw, tbl[i].m, tbl[i].a, tbl[i].d, lat, rd, fe, fw, ne);
         if (tbl[i].rw) model_write(tbl[i].a, tbl[i].m, tbl[i].d);
         chk_i($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
         chk($sformatf("tbl%0d_rd_data", i), {96'd0, rd}, {96'd0, tbl[i].rd});
         chk_i($sformatf("tbl%0d_mem_en_at", i), fe, tbl[i].en_at);
         chk_i($sformatf("tbl%0d_mem_we_at", i), fw, tbl[i].we_at);
         chk_i($sformatf("tbl%0d_mem_en_cycles", i), ne, tbl[i].n_en);
      end
      line_exp = 128'h33333333_22222222_DEADBEEF_00BB00DD;
      chk("line10_contents", mem[8'h10], line_exp);

      // Abort a write in WAIT: nothing may reach memory or the bus.
      @(negedge clk);
      en      = 1'b1;
      rdwr    = 1'b1;
      mask    = 4'hF;
      addr    = 32'h108;
      wr_data = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      chk("abort_rd_strobe", {127'd0, mem_en}, 128'd1);
      @(negedge clk);
      we0   = we_cnt;
      r0    = rdy_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_ready",    {127'd0, ready},    128'd0);
      chk("abort_mem_en",   {127'd0, mem_en},   128'd0);
      chk("abort_mem_we",   {127'd0, mem_we},   128'd0);
      chk("abort_rd_data",  {96'd0, rd_data},   128'd0);
      chk("abort_mem_addr", {100'd0, mem_addr}, 128'd0);
      chk("abort_wr_data",  mem_wr_data,        128'd0);
      en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk_i("abort_no_write", we_cnt, we0);
      chk_i("abort_no_ready", rdy_cnt, r0);
      txn(1'b0, 4'h0, 32'h108, 32'h0, lat, rd, fe, fw, ne);
      chk_i("abort_read_latency", lat, 3);
      chk("abort_read_data", {96'd0, rd}, {96'd0, 32'h22222222});

      for (int p = 0; p < 50; p++) begin
         ra   = 32'($urandom_range(0, 500));
         rm   = 4'($urandom);
         rdat = $urandom;
         txn(1'b1, rm, ra, rdat, lat, rd, fe, fw, ne);
         model_write(ra, rm, rdat);
         chk_i($sformatf("rnd%0d_wr_latency", p), lat, (rm == 4'h0) ? 1 : 4);
         rb = ($urandom_range(0, 1) == 1) ? ra : 32'($urandom_range(0, 500));
         txn(1'b0, 4'h0, rb, 32'h0, lat, rd, fe, fw, ne);
         chk_i($sformatf("rnd%0d_rd_latency", p), lat, 3);
         chk($sformatf("rnd%0d_rd_data@%0h", p, rb), {96'd0, rd},
             {96'd0, model_read(rb)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
